// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: rotating round-robin selection of up to NUM_CDB
// non-empty result queues, with registered broadcast lanes.
package cdb_pkg;
  typedef struct packed {
    logic        valid;
    logic [5:0]  tag;
    logic [31:0] data;
  } cdb_t;
endpackage

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int NUM_CDB = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [NUM_SRC-1:0]   q_empty,
  input  cdb_t [NUM_SRC-1:0]   q_dout,
  output logic [NUM_SRC-1:0]   q_deq,
  output cdb_t [NUM_CDB-1:0]   cdb_out,
  output logic                 grant_any
);

  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        ptr_nxt;
  logic [NUM_SRC-1:0]   req;
  logic [2*NUM_SRC-1:0] req_dbl;
  logic [NUM_SRC-1:0]   req_rot;
  logic [NUM_SRC-1:0]   rem;
  logic [NUM_SRC-1:0]   granted;
  logic [NUM_CDB-1:0]   lane_gnt;
  logic [PW-1:0]        lane_src [NUM_CDB];
  cdb_t [NUM_CDB-1:0]   lane_data;
  logic                 found;
  logic                 go;

  // Modular add over the source index space (NUM_SRC need not be a power of two).
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input logic [PW-1:0] off);
    logic [PW:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= (PW+1)'(NUM_SRC)) begin
      sum = sum - (PW+1)'(NUM_SRC);
    end else begin
      sum = sum;
    end
    return sum[PW-1:0];
  endfunction

  assign req     = ~q_empty;
  // Rotate so bit 0 of req_rot is the source at rr_ptr; scan order becomes 0..N-1.
  assign req_dbl = {req, req} >> rr_ptr;
  assign req_rot = req_dbl[NUM_SRC-1:0];
  assign go      = ~rst & ~flush;
  assign q_deq   = granted & {NUM_SRC{go}};

  // Lane selection, lane payloads and the next priority pointer.
  always_comb begin
    rem       = req_rot;
    lane_gnt  = '0;
    granted   = '0;
    lane_data = '0;
    ptr_nxt   = rr_ptr;
    found     = 1'b0;
    for (int k = 0; k < NUM_CDB; k++) begin
      lane_src[k] = '0;
    end
    // Each lane claims the first remaining requester, so no source gets two lanes.
    for (int k = 0; k < NUM_CDB; k++) begin
      found = 1'b0;
      for (int j = 0; j < NUM_SRC; j++) begin
        if (!found && rem[j]) begin
          found       = 1'b1;
          rem[j]      = 1'b0;
          lane_src[k] = wrap_add(rr_ptr, PW'(j));
        end else begin
          found = found;
        end
      end
      lane_gnt[k] = found;
    end
    for (int k = 0; k < NUM_CDB; k++) begin
      if (lane_gnt[k]) begin
        granted[lane_src[k]]  = 1'b1;
        lane_data[k]          = q_dout[lane_src[k]];
        lane_data[k].valid    = 1'b1;
        ptr_nxt               = wrap_add(lane_src[k], PW'(1));
      end else begin
        lane_data[k] = '0;
      end
    end
  end

  // Broadcast registers and priority pointer; reset and flush both clear them.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rr_ptr    <= '0;
      cdb_out   <= '0;
      grant_any <= 1'b0;
    end else begin
      rr_ptr    <= ptr_nxt;
      cdb_out   <= lane_data;
      grant_any <= |lane_gnt;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed-vector bench for cdb_arbiter: a single-lane and a dual-lane
// instance, hand-computed grant sequences, then a random scoreboard soak.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush;
  logic [3:0]         q_empty1, q_empty2;
  logic [3:0]         q_deq1, q_deq2;
  cdb_t [3:0]         q_dout1, q_dout2;
  cdb_t [0:0]         cdb_out1;
  cdb_t [1:0]         cdb_out2;
  logic               grant_any1, grant_any2;
  int                 seq1 [4];
  int                 seq2 [4];
  int                 n_tests = 0;
  int                 n_fail = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_SRC(4), .NUM_CDB(1)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .q_empty(q_empty1), .q_dout(q_dout1),
    .q_deq(q_deq1), .cdb_out(cdb_out1), .grant_any(grant_any1));

  cdb_arbiter #(.NUM_SRC(4), .NUM_CDB(2)) u2 (
    .clk(clk), .rst(rst), .flush(flush), .q_empty(q_empty2), .q_dout(q_dout2),
    .q_deq(q_deq2), .cdb_out(cdb_out2), .grant_any(grant_any2));

  // Queue head as stored (valid deliberately 0: the arbiter must force it).
  function automatic cdb_t mk(input int src, input int sq);
    cdb_t r;
    r.valid = 1'b0;
    r.tag   = 6'(src + 1);
    r.data  = {16'(sq), 8'hC0, 8'(src)};
    return r;
  endfunction

  function automatic cdb_t mkv(input int src, input int sq);
    cdb_t r;
    r = mk(src, sq);
    r.valid = 1'b1;
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      q_dout1[i] = mk(i, seq1[i]);
      q_dout2[i] = mk(i, seq2[i]);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One single-lane cycle: exp_src < 0 means no grant expected.
  task automatic step1(input string tag, input logic [3:0] emp, input logic [3:0] exp_deq,
                       input int exp_src, input int exp_ptr);
    cdb_t e;
    logic [3:0] d;
    q_empty1 = emp;
    #2;
    check({tag, ".deq"}, 64'(q_deq1), 64'(exp_deq));
    e = (exp_src < 0) ? cdb_t'('0) : mkv(exp_src, seq1[exp_src]);
    d = q_deq1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) if (d[i]) seq1[i]++;
    check({tag, ".cdb"}, 64'(cdb_out1[0]), 64'(e));
    check({tag, ".any"}, 64'(grant_any1), 64'(exp_src >= 0));
    check({tag, ".ptr"}, 64'(u1.rr_ptr), 64'(exp_ptr));
  endtask

  task automatic step2(input string tag, input logic [3:0] emp, input logic [3:0] exp_deq,
                       input int s0, input int s1, input int exp_ptr);
    cdb_t e0, e1;
    logic [3:0] d;
    q_empty2 = emp;
    #2;
    check({tag, ".deq"}, 64'(q_deq2), 64'(exp_deq));
    e0 = (s0 < 0) ? cdb_t'('0) : mkv(s0, seq2[s0]);
    e1 = (s1 < 0) ? cdb_t'('0) : mkv(s1, seq2[s1]);
    d = q_deq2;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) if (d[i]) seq2[i]++;
    check({tag, ".lane0"}, 64'(cdb_out2[0]), 64'(e0));
    check({tag, ".lane1"}, 64'(cdb_out2[1]), 64'(e1));
    check({tag, ".any"}, 64'(grant_any2), 64'(s0 >= 0));
    check({tag, ".ptr"}, 64'(u2.rr_ptr), 64'(exp_ptr));
  endtask

  initial begin
    int w1 [4];
    int w2 [4];
    for (int i = 0; i < 4; i++) begin
      seq1[i] = 0; seq2[i] = 0; w1[i] = 0; w2[i] = 0;
    end
    rst = 1'b1; flush = 1'b0; q_empty1 = 4'hF; q_empty2 = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle after reset.
    for (int c = 0; c < 3; c++) step1("idle", 4'b1111, 4'b0000, -1, 0);

    // Round robin with all sources busy.
    for (int c = 0; c < 8; c++) step1("rr", 4'b0000, 4'(1 << (c % 4)), c % 4, (c + 1) % 4);

    // Skip and wrap: move pointer to 3, then only sources 1 and 3 request.
    step1("wrap.set", 4'b1011, 4'b0100, 2, 3);
    step1("wrap.g3",  4'b0101, 4'b1000, 3, 0);
    step1("wrap.g1",  4'b0101, 4'b0010, 1, 2);

    // Flush mid-stream with sources 0 and 1 busy.
    step1("fl.pre", 4'b1100, 4'b0001, 0, 1);
    flush = 1'b1;
    #1;
    check("fl.visible", 64'(cdb_out1[0]), 64'(mkv(0, seq1[0] - 1)));
    step1("fl.cyc", 4'b1100, 4'b0000, -1, 0);
    flush = 1'b0;
    step1("fl.res0", 4'b1100, 4'b0001, 0, 1);
    step1("fl.res1", 4'b1100, 4'b0010, 1, 2);

    // Reset and flush together while everything requests.
    rst = 1'b1; flush = 1'b1; q_empty1 = 4'b0000; q_empty2 = 4'b0000;
    #2;
    check("rf.deq1", 64'(q_deq1), 64'(4'b0000));
    check("rf.deq2", 64'(q_deq2), 64'(4'b0000));
    @(posedge clk); #1;
    check("rf.cdb1", 64'(cdb_out1[0]), 64'd0);
    check("rf.cdb2", 64'(cdb_out2), 64'd0);
    check("rf.any", 64'({grant_any1, grant_any2}), 64'd0);
    check("rf.ptr1", 64'(u1.rr_ptr), 64'd0);
    check("rf.ptr2", 64'(u2.rr_ptr), 64'd0);
    rst = 1'b0; flush = 1'b0; q_empty1 = 4'hF; q_empty2 = 4'hF;

    // Dual lane.
    step2("dl.set",  4'b1100, 4'b0011, 0, 1, 2);
    step2("dl.p2",   4'b0010, 4'b1100, 2, 3, 0);
    step2("dl.p0",   4'b1110, 4'b0001, 0, -1, 1);
    step2("dl.all1", 4'b0000, 4'b0110, 1, 2, 3);
    step2("dl.wrap", 4'b0000, 4'b1001, 3, 0, 1);

    // Random soak: scoreboard on popped heads plus starvation bounds.
    for (int c = 0; c < 10000; c++) begin
      logic [3:0] d1, d2;
      cdb_t e1, h0, h1;
      int n2, want2, m1, m2;
      logic ok;
      q_empty1 = 4'($urandom & $urandom);
      q_empty2 = 4'($urandom & $urandom);
      #2;
      d1 = q_deq1; d2 = q_deq2;
      check("soak1.deq_empty", 64'(d1 & q_empty1), 64'd0);
      check("soak2.deq_empty", 64'(d2 & q_empty2), 64'd0);
      check("soak1.cnt", 64'($countones(d1)), 64'(q_empty1 != 4'hF));
      want2 = ($countones(~q_empty2) > 2) ? 2 : $countones(~q_empty2);
      n2 = $countones(d2);
      check("soak2.cnt", 64'(n2), 64'(want2));
      e1 = '0; h0 = '0; h1 = '0; m1 = 0; m2 = 0;
      for (int i = 0; i < 4; i++) begin
        if (d1[i]) e1 = mkv(i, seq1[i]);
        if (d2[i]) begin
          if (h0.valid) h1 = mkv(i, seq2[i]);
          else h0 = mkv(i, seq2[i]);
        end
        w1[i] = (!q_empty1[i] && !d1[i]) ? w1[i] + 1 : 0;
        w2[i] = (!q_empty2[i] && !d2[i]) ? w2[i] + 1 : 0;
        if (w1[i] > m1) m1 = w1[i];
        if (w2[i] > m2) m2 = w2[i];
      end
      check("soak1.fair", 64'(m1 <= 3), 64'd1);
      check("soak2.fair", 64'(m2 <= 1), 64'd1);
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (d1[i]) seq1[i]++;
        if (d2[i]) seq2[i]++;
      end
      check("soak1.cdb", 64'(cdb_out1[0]), 64'(e1));
      if (n2 == 0) ok = (cdb_out2 == '0);
      else if (n2 == 1) ok = (cdb_out2[0] == h0) && (cdb_out2[1] == '0);
      else ok = ((cdb_out2[0] == h0) && (cdb_out2[1] == h1)) ||
                ((cdb_out2[0] == h1) && (cdb_out2[1] == h0));
      check("soak2.lanes", 64'(ok), 64'd1);
      check("soak.any", 64'({grant_any1, grant_any2}), 64'({d1 != 4'b0, d2 != 4'b0}));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Downstream consumer of the per-functional-unit CDB result queues.
- Each cycle it selects up to NUM_CDB non-empty queues using rotating round-robin priority and pops their heads with a dequeue strobe.
- It drives the selected results onto registered common-data-bus lanes, which the ROB, reservation stations and register file snoop.
- A flush discards in-flight broadcasts and stops all dequeues.

Parameters:
- NUM_SRC, 4, number of source result queues (1..8).
- NUM_CDB, 1, number of CDB broadcast lanes (1..2, must be <= NUM_SRC).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  pipeline flush (mispredict/exception).
- q_empty  input  NUM_SRC  per-source queue empty flag; bit i = 1 means source i has nothing.
- q_dout  input  NUM_SRC x cdb_t  per-source queue head entry.
- q_deq  output  NUM_SRC  per-source dequeue strobe; goes to the source queue's deq_en.
- cdb_out  output  NUM_CDB x cdb_t  registered broadcast lanes; a lane's .valid marks a live result.
- grant_any  output  1  registered; 1 when at least one lane in cdb_out is valid.

Behaviour:
- Request: req[i] = ~q_empty[i]. The contents of q_dout[i] are ignored when q_empty[i] = 1.
- Priority pointer rr_ptr has width clog2(NUM_SRC), minimum 1 bit. Scan order is rr_ptr, rr_ptr+1, ... modulo NUM_SRC.
- Lane assignment:
  - Lane 0 takes the first requester in scan order.
  - Lane 1 (NUM_CDB = 2) takes the next distinct requester.
  - A source never receives two lanes in the same cycle.
- q_deq is combinational:
  - q_deq[i] = granted[i] & ~flush & ~rst.
  - At most NUM_CDB bits are set.
  - q_deq is never asserted for an empty source.
- cdb_out is registered:
  - Granted lane k: cdb_out[k] <= q_dout[src_k] with .valid forced to 1.
  - Ungranted lane: cdb_out[k] <= '0.
- Latency: a head visible at cycle t with a grant is broadcast during cycle t+1. Throughput is NUM_CDB results per cycle.
- rr_ptr update:
  - If any grant occurred: rr_ptr <= (highest-lane granted index + 1) mod NUM_SRC.
  - If no grant: rr_ptr is unchanged.
  - Wrap-around: a grant to index NUM_SRC-1 moves rr_ptr to 0.
- Fairness: a continuously requesting source is granted within ceil(NUM_SRC / NUM_CDB) cycles.
- No backpressure: the CDB consumer always accepts, and there is no hold path.
- Reset (rst = 1): rr_ptr <= 0, all cdb_out <= '0, grant_any <= 0, q_deq = 0. This holds when reset arrives mid-stream; a result registered on the previous cycle is dropped.
- Flush (rst = 0, flush = 1):
  - q_deq = 0.
  - All cdb_out <= '0 next cycle.
  - rr_ptr <= 0.
  - A result already sitting in cdb_out during the flush cycle stays visible for that cycle only. The ROB masks it.
- rst has priority over flush.
- grant_any <= OR of the per-lane grants, computed under the same rst/flush gating as cdb_out.
- Implementation: no latches; all state in a single clocked process. The grant logic is purely combinational from q_empty, rr_ptr, flush and rst.

Test Plan:
1. Reset, then NUM_SRC=4, NUM_CDB=1, q_empty=4'b1111 for 3 cycles -> q_deq=0, cdb_out[0].valid=0, grant_any=0, rr_ptr=0.
2. Round-robin: all four sources non-empty for 8 cycles, sources never drain.
   - Required grant order 0,1,2,3,0,1,2,3 on q_deq.
   - cdb_out[0] carries source i's head one cycle after q_deq[i].
3. Skip and wrap: rr_ptr=3, only sources 1 and 3 non-empty -> grant 3, then rr_ptr=0 and grant 1 next cycle, then rr_ptr=2.
4. Dual lane: NUM_CDB=2, rr_ptr=2, sources 0, 2, 3 non-empty.
   - q_deq=4'b1100, lane0=src2, lane1=src3 the following cycle, rr_ptr=0.
   - Next cycle: q_deq=4'b0001.
5. Flush mid-stream: sources 0 and 1 busy, flush asserted in cycle t.
   - q_deq=0 in cycle t.
   - cdb_out.valid=0 and grant_any=0 at t+1.
   - rr_ptr=0.
   - Grants resume from source 0 at t+1 if its queue is non-empty.
6. rst and flush both high while sources 0-3 request -> q_deq=0, outputs zero next cycle, rr_ptr=0.
   - Random soak: 10k cycles with a scoreboard checking no lost or duplicated results and each non-empty source granted within NUM_SRC cycles.
